// File: rtl/misc_issue_ctrl.sv
// Issue controller + writeback FIFO for the Misc64 unit: two-requester arbiter, 2-stage tag
// tracking, credit-gated DEPTH-entry result FIFO. Define MISC_ISSUE_RR_EN for round-robin arbitration.
module misc_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         nRESET,
  input  logic         REQ0,
  input  logic [2:0]   OPC0,
  input  logic [2:0]   SA0,
  input  logic [2:0]   SD0,
  input  logic [3:0]   DST0,
  input  logic [15:0]  CIN0,
  input  logic [127:0] A0,
  input  logic         REQ1,
  input  logic [2:0]   OPC1,
  input  logic [2:0]   SA1,
  input  logic [2:0]   SD1,
  input  logic [3:0]   DST1,
  input  logic [15:0]  CIN1,
  input  logic [127:0] A1,
  output logic         ACK0,
  output logic         ACK1,
  output logic         U_ACT,
  output logic [2:0]   U_OPCODE,
  output logic [2:0]   U_SA,
  output logic [2:0]   U_SD,
  output logic [3:0]   U_DST,
  output logic [15:0]  U_CIN,
  output logic [127:0] U_A,
  input  logic [127:0] U_R,
  input  logic         U_ZERO,
  input  logic         U_SIGN,
  input  logic         U_OVR,
  input  logic         U_COUT,
  input  logic         U_NAN,
  input  logic [2:0]   U_SR,
  output logic         WBRDY,
  input  logic         WBACK,
  output logic         WBSRC,
  output logic [3:0]   WBDST,
  output logic [127:0] WBR,
  output logic [4:0]   WBFLAGS,
  output logic [2:0]   WBSR
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic         src;
    logic [3:0]   dst;
    logic [127:0] r;
    logic [4:0]   flags;
    logic [2:0]   sr;
  } wb_entry_t;

  // [0] issue register, [1] P1, [2] P2
  logic [2:0]    vld_pipe;
  logic          u_src, p1_src, p2_src;
  logic [3:0]    p1_dst, p2_dst;
  logic [2:0]    p2_sr;
  wb_entry_t     mem [DEPTH];
  wb_entry_t     head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    inflight;
  logic [CW:0]   used;
  logic          credit_ok, grant, win1, push, pop;

  assign inflight  = 2'(vld_pipe[0]) + 2'(vld_pipe[1]) + 2'(vld_pipe[2]);
  assign used      = (CW+1)'(count) + (CW+1)'(inflight);
  assign credit_ok = used < (CW+1)'(DEPTH);

`ifdef MISC_ISSUE_RR_EN
  logic rr_ptr;
  assign win1 = (REQ0 && REQ1) ? rr_ptr : REQ1;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)    rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= ~win1;
  end
`else
  assign win1 = ~REQ0;
`endif

  // ACK is combinational, so gate it with reset to keep it low while nRESET is asserted
  assign grant = nRESET && credit_ok && (REQ0 || REQ1);
  assign ACK0  = grant && !win1;
  assign ACK1  = grant && win1;
  assign U_ACT = vld_pipe[0];

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      vld_pipe <= '0;
      U_OPCODE <= '0;
      U_SA     <= '0;
      U_SD     <= '0;
      U_DST    <= '0;
      U_CIN    <= '0;
      U_A      <= '0;
      u_src    <= 1'b0;
      p1_src   <= 1'b0;
      p1_dst   <= '0;
      p2_src   <= 1'b0;
      p2_dst   <= '0;
      p2_sr    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], grant};
      if (grant) begin
        U_OPCODE <= win1 ? OPC1 : OPC0;
        U_SA     <= win1 ? SA1  : SA0;
        U_SD     <= win1 ? SD1  : SD0;
        U_DST    <= win1 ? DST1 : DST0;
        U_CIN    <= win1 ? CIN1 : CIN0;
        U_A      <= win1 ? A1   : A0;
        u_src    <= win1;
      end
      if (vld_pipe[0]) begin
        p1_src <= u_src;
        p1_dst <= U_DST;
      end
      // the unit presents SR a stage before R, so it is held alongside the P2 tag
      if (vld_pipe[1]) begin
        p2_src <= p1_src;
        p2_dst <= p1_dst;
        p2_sr  <= U_SR;
      end
    end
  end

  assign push = vld_pipe[2];
  assign pop  = WBACK && (count != '0);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= '{src: p2_src, dst: p2_dst, r: U_R,
                       flags: {U_ZERO, U_SIGN, U_OVR, U_COUT, U_NAN}, sr: p2_sr};
  end

  // storage is not reset; head fields are masked to zero whenever the FIFO is empty
  assign head    = mem[rd_ptr];
  assign WBRDY   = (count != '0);
  assign WBSRC   = WBRDY && head.src;
  assign WBDST   = WBRDY ? head.dst   : '0;
  assign WBR     = WBRDY ? head.r     : '0;
  assign WBFLAGS = WBRDY ? head.flags : '0;
  assign WBSR    = WBRDY ? head.sr    : '0;
endmodule

// File: tb/tb_misc_issue_ctrl.sv
// Directed bench for misc_issue_ctrl with a small 2-stage model of the Misc64 unit.
module tb_misc_issue_ctrl;
  localparam int DEPTH = 4;

  logic CLK = 1'b0, nRESET;
  logic REQ0, REQ1, ACK0, ACK1, U_ACT, WBRDY, WBACK, WBSRC;
  logic [2:0] OPC0, SA0, SD0, OPC1, SA1, SD1, U_OPCODE, U_SA, U_SD, U_SR, WBSR;
  logic [3:0] DST0, DST1, U_DST, WBDST;
  logic [15:0] CIN0, CIN1, U_CIN;
  logic [127:0] A0, A1, U_A, U_R, WBR;
  logic U_ZERO, U_SIGN, U_OVR, U_COUT, U_NAN;
  logic [4:0] WBFLAGS;

  misc_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .REQ0(REQ0), .OPC0(OPC0), .SA0(SA0), .SD0(SD0), .DST0(DST0), .CIN0(CIN0), .A0(A0),
    .REQ1(REQ1), .OPC1(OPC1), .SA1(SA1), .SD1(SD1), .DST1(DST1), .CIN1(CIN1), .A1(A1),
    .ACK0(ACK0), .ACK1(ACK1), .U_ACT(U_ACT), .U_OPCODE(U_OPCODE), .U_SA(U_SA), .U_SD(U_SD),
    .U_DST(U_DST), .U_CIN(U_CIN), .U_A(U_A), .U_R(U_R), .U_ZERO(U_ZERO), .U_SIGN(U_SIGN),
    .U_OVR(U_OVR), .U_COUT(U_COUT), .U_NAN(U_NAN), .U_SR(U_SR), .WBRDY(WBRDY), .WBACK(WBACK),
    .WBSRC(WBSRC), .WBDST(WBDST), .WBR(WBR), .WBFLAGS(WBFLAGS), .WBSR(WBSR)
  );

  always #5 CLK = ~CLK;

  // unit model: opcode 000 BSWAP, 011 NEG, 101 POS (lowest set bit), others pass A through
  function automatic logic [127:0] unit_f(input logic [2:0] opc, input logic [127:0] a);
    logic [127:0] r;
    r = a;
    case (opc)
      3'b000: for (int i = 0; i < 16; i++) r[8*i +: 8] = a[8*(15-i) +: 8];
      3'b011: r = -a;
      3'b101: begin
        r = '0;
        for (int i = 127; i >= 0; i--) if (a[i]) r = 128'(i);
      end
      default: r = a;
    endcase
    return r;
  endfunction

  logic [2:0]   s1_opc = '0;
  logic [127:0] s1_a = '0;
  logic [127:0] nr;
  assign nr = unit_f(s1_opc, s1_a);
  always @(posedge CLK) begin
    if (U_ACT) begin
      s1_opc <= U_OPCODE;
      s1_a   <= U_A;
      U_SR   <= U_SA;
    end
    U_R    <= nr;
    U_ZERO <= (nr == '0);
    U_SIGN <= nr[127];
    U_OVR  <= 1'b0;
    U_COUT <= (s1_opc == 3'b011) && (s1_a != '0);
    U_NAN  <= 1'b0;
  end

  logic bound_err = 1'b0;
  always @(negedge CLK) if (nRESET === 1'b1 && dut.count > DEPTH) bound_err <= 1'b1;

  int vecs = 0, miss = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic k, input logic [2:0] opc, input logic [2:0] sa,
                       input logic [3:0] dst, input logic [127:0] a);
    if (!k) begin REQ0 = 1'b1; OPC0 = opc; SA0 = sa; SD0 = sa; DST0 = dst; A0 = a; end
    else    begin REQ1 = 1'b1; OPC1 = opc; SA1 = sa; SD1 = sa; DST1 = dst; A1 = a; end
  endtask

  typedef struct {
    logic         src;
    logic [2:0]   opc;
    logic [2:0]   sa;
    logic [3:0]   dst;
    logic [127:0] a;
    logic [127:0] exp_r;
    logic [4:0]   exp_flags;
  } vec_t;

  vec_t tbl [5];
  logic grants [6];
  int n, acks, got, g;

  initial begin
    tbl[0] = '{1'b0, 3'b011, 3'd3, 4'd7,  128'd5, {{125{1'b1}}, 3'b011}, 5'b01010};
    tbl[1] = '{1'b1, 3'b011, 3'd1, 4'd2,  128'd0, 128'd0, 5'b10000};
    tbl[2] = '{1'b0, 3'b000, 3'd7, 4'd15, 128'h00112233445566778899AABBCCDDEEFF,
               128'hFFEEDDCCBBAA99887766554433221100, 5'b01000};
    tbl[3] = '{1'b1, 3'b101, 3'd2, 4'd0,  128'h8, 128'd3, 5'b00000};
    tbl[4] = '{1'b0, 3'b101, 3'd4, 4'd9,  128'd1 << 100, 128'd100, 5'b00000};

    nRESET = 1'b0; WBACK = 1'b0;
    REQ0 = 1'b0; OPC0 = '0; SA0 = '0; SD0 = '0; DST0 = '0; CIN0 = 16'h1234; A0 = '0;
    REQ1 = 1'b0; OPC1 = '0; SA1 = '0; SD1 = '0; DST1 = '0; CIN1 = 16'h5678; A1 = '0;

    // reset state, with a request pending to prove ACK is held low
    REQ0 = 1'b1;
    #3;
    chk("rst_ack0", ACK0, 0);
    chk("rst_wbrdy", WBRDY, 0);
    chk("rst_uact", U_ACT, 0);
    chk("rst_ua", U_A, 0);
    chk("rst_wbr", WBR, 0);
    REQ0 = 1'b0;
    step(); step();
    nRESET = 1'b1;

    // single-op vectors: ACK at t, U_ACT at t+1, WBRDY only from t+4
    for (int i = 0; i < 5; i++) begin
      step();
      drive(tbl[i].src, tbl[i].opc, tbl[i].sa, tbl[i].dst, tbl[i].a);
      #1;
      chk("v_ack", tbl[i].src ? ACK1 : ACK0, 1);
      chk("v_ack_other", tbl[i].src ? ACK0 : ACK1, 0);
      step();
      REQ0 = 1'b0; REQ1 = 1'b0;
      #1;
      chk("v_uact", U_ACT, 1);
      chk("v_udst", U_DST, tbl[i].dst);
      step(); step();
      #1;
      chk("v_early", WBRDY, 0);
      step();
      chk("v_wbrdy", WBRDY, 1);
      chk("v_wbr", WBR, tbl[i].exp_r);
      chk("v_wbdst", WBDST, tbl[i].dst);
      chk("v_wbsrc", WBSRC, tbl[i].src);
      chk("v_wbsr", WBSR, tbl[i].sa);
      chk("v_wbflags", WBFLAGS, tbl[i].exp_flags);
      WBACK = 1'b1;
      step();
      WBACK = 1'b0;
      #1;
      chk("v_popped", WBRDY, 0);
    end

    // backpressure: exactly DEPTH grants with no pops, then one more per pop
    n = 0; acks = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 3'b000, 3'd7, 4'(n), 128'(n + 1));
      #1;
      if (ACK0) begin acks++; n++; end
      step();
    end
    chk("bp_acks", acks, 4);
    drive(1'b0, 3'b000, 3'd7, 4'(n), 128'(n + 1));
    #1;
    chk("bp_stall", ACK0, 0);
    WBACK = 1'b1;
    #1;
    chk("bp_same_cycle", ACK0, 0);
    chk("bp_head", WBDST, 0);
    step();
    WBACK = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 3'b000, 3'd7, 4'(n), 128'(n + 1));
      #1;
      if (ACK0) begin acks++; n++; end
      step();
    end
    chk("bp_one_more", acks, 1);
    REQ0 = 1'b0;
    WBACK = 1'b1;
    got = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (WBRDY) begin
        chk("bp_dst", WBDST, 4'(got));
        chk("bp_r", WBR, {8'(got + 1), 120'h0});
        got++;
      end
      step();
    end
    chk("bp_count", got, 5);

    // arbitration from a fresh reset so the round-robin pointer starts at 0
    nRESET = 1'b0;
    #2;
    nRESET = 1'b1;
    step();
    drive(1'b0, 3'b001, 3'd1, 4'd1, 128'h10);
    drive(1'b1, 3'b001, 3'd1, 4'd2, 128'h20);
    g = 0;
    for (int c = 0; c < 30 && g < 6; c++) begin
      #1;
      if (ACK0 || ACK1) begin
        chk("arb_onehot", ACK0 && ACK1, 0);
        grants[g] = ACK1;
        g++;
      end
      step();
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("arb_grants", g, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef MISC_ISSUE_RR_EN
      chk("arb_order", grants[i], 1'(i % 2));
`else
      chk("arb_order", grants[i], 0);
`endif
    end
    for (int c = 0; c < 10; c++) step();
    chk("arb_drained", WBRDY, 0);

    // back-to-back POS: results on consecutive cycles t+4..t+7 in issue order
    for (int k = 0; k < 9; k++) begin
      if (k < 4) drive(1'b0, 3'b101, 3'd0, 4'(k + 1), 128'(1 << k));
      else REQ0 = 1'b0;
      #1;
      if (k < 4) chk("ord_ack", ACK0, 1);
      if (k >= 4 && k < 8) begin
        chk("ord_rdy", WBRDY, 1);
        chk("ord_dst", WBDST, 4'(k - 3));
        chk("ord_r", WBR, 128'(k - 4));
      end
      if (k == 8) chk("ord_empty", WBRDY, 0);
      step();
    end

    // simultaneous push and pop with two entries queued
    WBACK = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 3) drive(1'b0, 3'b001, 3'd2, 4'(9 + k), 128'(100 + k));
      else REQ0 = 1'b0;
      if (k == 5) WBACK = 1'b1;
      #1;
      if (k < 3) chk("pp_ack", ACK0, 1);
      if (k == 5) begin
        chk("pp_count_before", dut.count, 2);
        chk("pp_head_before", WBDST, 9);
      end
      if (k == 6) begin
        chk("pp_count_after", dut.count, 2);
        chk("pp_head_after", WBDST, 10);
      end
      step();
    end
    WBACK = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("pp_drained", WBRDY, 0);
    WBACK = 1'b0;

    // reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b001, 3'd1, 4'(5 + k), 128'(k + 7));
      #1;
      chk("rm_ack", ACK0, 1);
      step();
    end
    drive(1'b0, 3'b011, 3'd5, 4'd12, 128'd2);
    nRESET = 1'b0;
    #1;
    chk("rm_ack0", ACK0, 0);
    chk("rm_wbrdy", WBRDY, 0);
    chk("rm_uact", U_ACT, 0);
    chk("rm_udst", U_DST, 0);
    chk("rm_ua", U_A, 0);
    chk("rm_uopc", U_OPCODE, 0);
    chk("rm_wbdst", WBDST, 0);
    step();
    nRESET = 1'b1;
    #1;
    chk("rm_first_ack", ACK0, 1);
    step();
    REQ0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rm_no_stale", WBRDY, 0);
      step();
    end
    chk("rm_rdy", WBRDY, 1);
    chk("rm_dst", WBDST, 12);
    chk("rm_r", WBR, {{126{1'b1}}, 2'b10});
    chk("rm_sr", WBSR, 5);
    WBACK = 1'b1;
    step();
    WBACK = 1'b0;

    chk("count_bound", bound_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
